// File: rtl/isolde_instr_batch_buffer_if.sv
// Fetch-side and decoder-side signals of the ISOLDE instruction batch buffer.
// The slave modport is the buffer; the master modport is the fetch/decode environment.
interface isolde_instr_batch_buffer_if #(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                word_valid_i;
    logic [31:0]         word_i;
    logic                word_ready_o;
    logic [4:0][31:0]    batch_o;
    logic [2:0]          batch_len_o;
    logic                batch_valid_o;
    logic                batch_illegal_o;
    logic                batch_pop_i;
    logic [CNT_W-1:0]    count_o;

    modport master (
        output word_valid_i, word_i, batch_pop_i,
        input  word_ready_o, batch_o, batch_len_o, batch_valid_o, batch_illegal_o, count_o
    );

    modport slave (
        input  word_valid_i, word_i, batch_pop_i,
        output word_ready_o, batch_o, batch_len_o, batch_valid_o, batch_illegal_o, count_o
    );
endinterface

// File: rtl/isolde_instr_batch_buffer.sv
// Circular word FIFO that presents whole variable-length ISOLDE instructions to the decoder.
// Optional macro ISOLDE_BATCH_PERF_EN adds stall_cnt_o, counting fetch-starved FILLING cycles.
module isolde_instr_batch_buffer #(
    parameter int unsigned DEPTH      = 8,
    parameter logic [6:0]  ISOLDE_OPC = 7'h0B
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
`ifdef ISOLDE_BATCH_PERF_EN
    output logic [31:0] stall_cnt_o,
`endif
    isolde_instr_batch_buffer_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {EMPTY, FILLING, READY} state_e;

    logic [31:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    state_e           state_q, state_d;
    logic             pop_err_q, pop_err_d;

    logic [4:0][31:0] batch;
    logic [2:0]       head_len;
    logic             head_illegal;
    logic             valid_comb;
    logic             push, pop;
    logic [CNT_W-1:0] remain;
    logic [31:0]      next_head;
    logic [2:0]       next_len;

    // Reserved length codes (5..7) decode as a single word so the decoder can pop and trap.
    function automatic logic [2:0] instr_len(input logic [31:0] w);
        logic [2:0] len;
        len = 3'd1;
        if (w[6:0] == ISOLDE_OPC && w[14:12] <= 3'd4) begin
            len = w[14:12] + 3'd1;
        end
        return len;
    endfunction

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            batch[i] = '0;
            if (CNT_W'(i) < count_q) begin
                batch[i] = mem_q[rd_ptr_q + PTR_W'(i)];
            end
        end
    end

    assign head_len     = instr_len(batch[0]);
    assign head_illegal = (batch[0][6:0] == ISOLDE_OPC) && (batch[0][14:12] > 3'd4);
    assign valid_comb   = (count_q != '0) && (count_q >= CNT_W'(head_len));

    assign bus.batch_o         = batch;
    assign bus.batch_len_o     = head_len;
    assign bus.batch_illegal_o = head_illegal;
    assign bus.batch_valid_o   = (state_q == READY);
    assign bus.count_o         = count_q;
    // Ready looks only at registered occupancy; space freed by a pop is usable next cycle.
    assign bus.word_ready_o    = (count_q < CNT_W'(DEPTH)) && !flush_i;

    assign push = bus.word_valid_i && bus.word_ready_o;
    assign pop  = bus.batch_pop_i && bus.batch_valid_o && !flush_i;

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        state_d   = state_q;
        pop_err_d = pop_err_q;
        remain    = count_q;
        next_head = '0;
        next_len  = 3'd1;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            state_d  = EMPTY;
        end else begin
            if (bus.batch_pop_i && !bus.batch_valid_o) begin
                pop_err_d = 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(head_len);
                remain   = count_q - CNT_W'(head_len);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            count_d = remain + CNT_W'(push);
            // When the pop drains everything, the incoming word becomes the new head.
            next_head = (remain == '0) ? bus.word_i : mem_q[rd_ptr_d];
            next_len  = instr_len(next_head);
            if (count_d == '0) begin
                state_d = EMPTY;
            end else if (count_d >= CNT_W'(next_len)) begin
                state_d = READY;
            end else begin
                state_d = FILLING;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= EMPTY;
            pop_err_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            pop_err_q <= pop_err_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= bus.word_i;
        end
    end

`ifdef ISOLDE_BATCH_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if (flush_i) begin
            stall_cnt_q <= '0;
        end else if (state_q == FILLING && !bus.word_valid_i && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

    // The registered READY state must always agree with the occupancy/length comparison.
    assert property (@(posedge clk_i) disable iff (!rst_ni) (state_q == READY) == valid_comb);
    cover property (@(posedge clk_i) disable iff (!rst_ni) pop_err_q);

endmodule

// File: tb/tb_isolde_instr_batch_buffer.sv
// Drives the batch buffer with directed scenarios and random traffic, comparing every
// cycle against a queue-based model of the instruction stream.
module tb_isolde_instr_batch_buffer;
    localparam int unsigned DEPTH = 8;

    logic clk;
    logic rst_n;
    logic flush;
    int   checks;
    int   errors;
    logic [31:0] q [$];

    isolde_instr_batch_buffer_if #(.DEPTH(DEPTH)) bus ();

`ifdef ISOLDE_BATCH_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] exp_stall;
`endif

    isolde_instr_batch_buffer #(.DEPTH(DEPTH), .ISOLDE_OPC(7'h0B)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush),
`ifdef ISOLDE_BATCH_PERF_EN
        .stall_cnt_o (stall_cnt),
`endif
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [159:0] observed, input logic [159:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] modelHead();
        logic [31:0] h;
        h = '0;
        if (q.size() > 0) h = q[0];
        return h;
    endfunction

    function automatic int modelLen();
        logic [31:0] h;
        h = modelHead();
        if (h[6:0] == 7'h0B && h[14:12] <= 3'd4) return int'(h[14:12]) + 1;
        return 1;
    endfunction

    function automatic logic modelValid();
        return (q.size() > 0) && (q.size() >= modelLen());
    endfunction

    task automatic checkAll(input string ph);
        logic [159:0] eb;
        logic [31:0]  h;
        eb = '0;
        for (int i = 0; i < 5; i++) begin
            if (i < q.size()) eb[i*32 +: 32] = q[i];
        end
        h = modelHead();
        checkOutput($sformatf("%s:count", ph), 160'(bus.count_o), 160'(q.size()));
        checkOutput($sformatf("%s:ready", ph), 160'(bus.word_ready_o), 160'((q.size() < DEPTH) && !flush));
        checkOutput($sformatf("%s:valid", ph), 160'(bus.batch_valid_o), 160'(modelValid()));
        checkOutput($sformatf("%s:len", ph), 160'(bus.batch_len_o), 160'(modelLen()));
        checkOutput($sformatf("%s:illegal", ph), 160'(bus.batch_illegal_o),
                    160'(h[6:0] == 7'h0B && h[14:12] > 3'd4));
        checkOutput($sformatf("%s:batch", ph), bus.batch_o, eb);
`ifdef ISOLDE_BATCH_PERF_EN
        checkOutput($sformatf("%s:stall", ph), 160'(stall_cnt), 160'(exp_stall));
`endif
    endtask

    // One clock: drive after the falling edge, check, then advance the model at the rising edge.
    task automatic applyStimulus(input string ph, input logic wv, input logic [31:0] w,
                                 input logic pop, input logic fl);
        logic push_ok, pop_ok, filling;
        int   len;
        @(negedge clk);
        bus.word_valid_i = wv;
        bus.word_i       = w;
        bus.batch_pop_i  = pop;
        flush            = fl;
        #1;
        checkAll(ph);
        push_ok = wv && (q.size() < DEPTH) && !fl;
        pop_ok  = pop && modelValid() && !fl;
        filling = (q.size() > 0) && !modelValid();
        len     = modelLen();
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (pop_ok) for (int i = 0; i < len; i++) void'(q.pop_front());
            if (push_ok) q.push_back(w);
        end
`ifdef ISOLDE_BATCH_PERF_EN
        if (fl) exp_stall = '0;
        else if (filling && !wv && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 1;
`else
        if (filling) len = 0;
`endif
    endtask

    task automatic idle(input string ph);
        applyStimulus(ph, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] randWord();
        logic [31:0] r;
        logic [2:0]  nnn;
        r   = $urandom;
        nnn = 3'($urandom_range(7, 0));
        if ($urandom_range(1, 0) == 1) return {r[31:15], nnn, r[11:7], 7'h0B};
        return {r[31:7], 7'h33};
    endfunction

    initial begin
        logic [31:0] w;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        flush  = 1'b0;
        bus.word_valid_i = 1'b0;
        bus.word_i       = '0;
        bus.batch_pop_i  = 1'b0;
`ifdef ISOLDE_BATCH_PERF_EN
        exp_stall = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset");
        checkOutput("reset_ready", 160'(bus.word_ready_o), 160'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // Single-word instruction round trip.
        applyStimulus("push33", 1'b1, 32'h0000_0033, 1'b0, 1'b0);
        #2;
        checkOutput("single_valid", 160'(bus.batch_valid_o), 160'(1));
        checkOutput("single_head", 160'(bus.batch_o[0]), 160'(32'h33));
        applyStimulus("pop33", 1'b0, 32'h0, 1'b1, 1'b0);
        idle("after_pop33");

        // Five-word instruction becomes valid only with all words resident.
        applyStimulus("len5_h", 1'b1, 32'h0000_400B, 1'b0, 1'b0);
        for (int i = 1; i < 4; i++) applyStimulus("len5_b", 1'b1, 32'hA000_0000 + i, 1'b0, 1'b0);
        #2;
        checkOutput("len5_partial_valid", 160'(bus.batch_valid_o), 160'(0));
        applyStimulus("len5_last", 1'b1, 32'hA000_0004, 1'b0, 1'b0);
        #2;
        checkOutput("len5_len", 160'(bus.batch_len_o), 160'(5));
        applyStimulus("len5_pop", 1'b0, 32'h0, 1'b1, 1'b0);
        idle("len5_empty");

        // Full buffer: pop of a two-word head does not make room in the same cycle.
        applyStimulus("full_h", 1'b1, 32'h0000_100B, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) applyStimulus("full_b", 1'b1, 32'h0000_0033, 1'b0, 1'b0);
        #2;
        checkOutput("full_ready", 160'(bus.word_ready_o), 160'(0));
        applyStimulus("full_poppush", 1'b1, 32'hBEEF_0033, 1'b1, 1'b0);
        #2;
        checkOutput("full_count6", 160'(bus.count_o), 160'(6));
        applyStimulus("full_push", 1'b1, 32'hBEEF_0033, 1'b0, 1'b0);
        #2;
        checkOutput("full_count7", 160'(bus.count_o), 160'(7));
        applyStimulus("full_flush", 1'b0, 32'h0, 1'b0, 1'b1);

        // Reserved length code is reported illegal and pops as one word.
        applyStimulus("ill_h", 1'b1, 32'h0000_600B, 1'b0, 1'b0);
        applyStimulus("ill_b", 1'b1, 32'h0000_0033, 1'b0, 1'b0);
        #2;
        checkOutput("ill_flag", 160'(bus.batch_illegal_o), 160'(1));
        applyStimulus("ill_pop", 1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus("ill_flush", 1'b0, 32'h0, 1'b0, 1'b1);

        // Advance pointers to 6, then a five-word instruction wraps the storage end.
        for (int i = 0; i < 6; i++) applyStimulus("pre_push", 1'b1, 32'h0000_0033, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus("pre_pop", 1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus("wrap_h", 1'b1, 32'h1234_400B, 1'b0, 1'b0);
        for (int i = 1; i < 5; i++) applyStimulus("wrap_b", 1'b1, 32'hC0DE_0000 + i, 1'b0, 1'b0);
        #2;
        checkOutput("wrap_slot4", 160'(bus.batch_o[4]), 160'(32'hC0DE_0004));

        // Flush beats a concurrent push and pop.
        applyStimulus("fl_pop", 1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus("fl_fill", 1'b1, 32'h0000_0033, 1'b0, 1'b0);
        applyStimulus("fl_all", 1'b1, 32'h0000_0033, 1'b1, 1'b1);
        #2;
        checkOutput("flush_count", 160'(bus.count_o), 160'(0));
        checkOutput("flush_valid", 160'(bus.batch_valid_o), 160'(0));

        // Asynchronous reset in the middle of a partial instruction.
        applyStimulus("rst_h", 1'b1, 32'h0000_400B, 1'b0, 1'b0);
        applyStimulus("rst_b", 1'b1, 32'h0000_0033, 1'b0, 1'b0);
        bus.word_valid_i = 1'b0;
        #3;
        rst_n = 1'b0;
        q.delete();
`ifdef ISOLDE_BATCH_PERF_EN
        exp_stall = '0;
`endif
        #1;
        checkAll("midreset");
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against the queue model.
        for (int n = 0; n < 600; n++) begin
            w = randWord();
            applyStimulus("rand", 1'($urandom_range(9, 0) < 7), w,
                          1'($urandom_range(1, 0)), 1'($urandom_range(39, 0) == 0));
        end
        idle("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
